// File: rtl/jk_excitation_driver_pkg.sv
// Shared types for the JK excitation driver: FSM state encoding and counter width.
package jk_excitation_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake between a requester (master) and the JK excitation driver (slave).
interface jk_excitation_driver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excitation_driver_enc.sv
// One-bit JK excitation encoder; DC_ZERO picks how the don't-care input is resolved.
module jk_excite_enc #(
    parameter bit DC_ZERO = 1'b1
) (
    input  logic q_now,
    input  logic q_next,
    output logic j,
    output logic k
);
    // Both styles give identical required J/K values; they differ only in the X entries.
    if (DC_ZERO) begin : g_set_reset
        assign j = ~q_now & q_next;
        assign k = q_now & ~q_next;
    end else begin : g_toggle
        assign j = q_now | q_next;
        assign k = ~q_now | ~q_next;
    end
endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a WIDTH-bit JK bank to a requested word for one clock, then checks its Q.
// Optional feature: define JK_DRV_COUNT_EN to add the saturating xfer_cnt output.
module jk_excitation_driver
    import jk_excitation_driver_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter bit          DC_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    jk_excitation_driver_if.slave  tgt,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [WIDTH-1:0]       j,
    output logic [WIDTH-1:0]       k,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [WIDTH-1:0]       err_bits,
    input  logic                   err_clr
`ifdef JK_DRV_COUNT_EN
    ,output logic [CNT_W-1:0]      xfer_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] enc_j;
    logic [WIDTH-1:0] enc_k;
    logic [WIDTH-1:0] mism;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        jk_excite_enc #(.DC_ZERO(DC_ZERO)) u_enc (
            .q_now  (q_fb[i]),
            .q_next (tgt.tgt_data[i]),
            .j      (enc_j[i]),
            .k      (enc_k[i])
        );
    end

    assign mism   = q_fb ^ tgt_q;
    assign accept = tgt.tgt_valid & tgt.tgt_ready;

    always_comb begin
        state_nxt     = state;
        tgt.tgt_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            ST_IDLE: begin
                tgt.tgt_ready = 1'b1;
                if (tgt.tgt_valid) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                busy      = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // j/k are zero in every cycle except the one following acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j        <= '0;
            k        <= '0;
            tgt_q    <= '0;
            err      <= 1'b0;
            err_bits <= '0;
        end else begin
            j <= '0;
            k <= '0;
            if (accept) begin
                tgt_q <= tgt.tgt_data;
                j     <= enc_j;
                k     <= enc_k;
            end
            // A fresh mismatch beats a simultaneous clear, keeping only the new bits.
            if (done && (|mism)) begin
                err      <= 1'b1;
                err_bits <= err_clr ? mism : (err_bits | mism);
            end else if (err_clr) begin
                err      <= 1'b0;
                err_bits <= '0;
            end
        end
    end

`ifdef JK_DRV_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (err_clr) begin
            xfer_cnt <= done ? CNT_W'(1) : '0;
        end else if (done && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule
